// File: rtl/muldiv_unit_if.sv
// Request/result bundle between a register-file-fed issue stage and muldiv_unit.
//   Start, Op, OperandA, OperandB, DestIn : request side, driven by the issuer
//   Busy                                  : unit is in RUN or DONE
//   WriteData, WriteReg, RegWrite         : register-file write port
//   DivByZero                             : flags a zero divisor with RegWrite
interface muldiv_unit_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 2
);
    logic              Start;
    logic [1:0]        Op;
    logic [WIDTH-1:0]  OperandA;
    logic [WIDTH-1:0]  OperandB;
    logic [ADDR_W-1:0] DestIn;
    logic              Busy;
    logic [WIDTH-1:0]  WriteData;
    logic [ADDR_W-1:0] WriteReg;
    logic              RegWrite;
    logic              DivByZero;

    modport master (
        output Start, Op, OperandA, OperandB, DestIn,
        input  Busy, WriteData, WriteReg, RegWrite, DivByZero
    );

    modport slave (
        input  Start, Op, OperandA, OperandB, DestIn,
        output Busy, WriteData, WriteReg, RegWrite, DivByZero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply (LSB first) and
// restoring divide (MSB first), one bit per cycle, result written back to the
// register file as a single-cycle RegWrite pulse WIDTH+1 cycles after Start.
//   Clock  : rising-edge clock
//   ResetN : asynchronous active-low reset, aborts any operation in flight
//   bus    : muldiv_unit_if slave (request inputs, write-port outputs)
module muldiv_unit #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 2
) (
    input  logic          Clock,
    input  logic          ResetN,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    aReg;      // multiplicand / dividend (shifts left on divide)
    logic [WIDTH-1:0]    bReg;      // multiplier (shifts right) / divisor (fixed)
    logic [1:0]          opReg;
    logic [ADDR_W-1:0]   destReg;
    logic [2*WIDTH-1:0]  acc;       // product, or quotient in the low half
    logic [WIDTH:0]      rem;       // partial remainder
    logic [CNT_W-1:0]    cnt;

    logic [WIDTH:0]      mulSum;
    logic [WIDTH:0]      shiftedRem;
    logic [WIDTH+1:0]    trialDiff;
    logic                qBit;
    logic [WIDTH:0]      remNext;
    logic [2*WIDTH-1:0]  accNext;
    logic [WIDTH-1:0]    resultNext;
    logic                unusedRemMsb;

    // The partial remainder never exceeds the divisor, so its top bit only
    // exists to keep the trial subtraction wide enough.
    assign unusedRemMsb = rem[WIDTH];

    // One iteration of either datapath, plus the result it would produce.
    always_comb begin
        mulSum     = (WIDTH+1)'(acc[2*WIDTH-1:WIDTH]) + (WIDTH+1)'(bReg[0] ? aReg : '0);
        shiftedRem = {rem[WIDTH-1:0], aReg[WIDTH-1]};
        trialDiff  = (WIDTH+2)'(shiftedRem) - (WIDTH+2)'(bReg);
        qBit       = ~trialDiff[WIDTH+1];
        remNext    = qBit ? trialDiff[WIDTH:0] : shiftedRem;
        if (opReg[1]) begin
            accNext = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], qBit};
        end else begin
            accNext = {mulSum, acc[WIDTH-1:1]};
        end
        case (opReg)
            2'b00:   resultNext = accNext[WIDTH-1:0];
            2'b01:   resultNext = accNext[2*WIDTH-1:WIDTH];
            2'b10:   resultNext = accNext[WIDTH-1:0];
            default: resultNext = remNext[WIDTH-1:0];
        endcase
    end

    // Control FSM, iteration registers and registered write-port outputs.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state         <= IDLE;
            aReg          <= '0;
            bReg          <= '0;
            opReg         <= '0;
            destReg       <= '0;
            acc           <= '0;
            rem           <= '0;
            cnt           <= '0;
            bus.Busy      <= 1'b0;
            bus.WriteData <= '0;
            bus.WriteReg  <= '0;
            bus.RegWrite  <= 1'b0;
            bus.DivByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.RegWrite  <= 1'b0;
                    bus.DivByZero <= 1'b0;
                    if (bus.Start) begin
                        aReg     <= bus.OperandA;
                        bReg     <= bus.OperandB;
                        opReg    <= bus.Op;
                        destReg  <= bus.DestIn;
                        acc      <= '0;
                        rem      <= '0;
                        cnt      <= '0;
                        bus.Busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= accNext;
                    rem <= remNext;
                    if (opReg[1]) begin
                        aReg <= {aReg[WIDTH-2:0], 1'b0};
                    end else begin
                        bReg <= {1'b0, bReg[WIDTH-1:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        bus.RegWrite  <= 1'b1;
                        bus.WriteData <= resultNext;
                        bus.WriteReg  <= destReg;
                        // Divisor is never shifted, so bReg still holds it here.
                        bus.DivByZero <= opReg[1] && (bReg == '0);
                        state         <= DONE;
                    end
                end
                DONE: begin
                    bus.RegWrite  <= 1'b0;
                    bus.DivByZero <= 1'b0;
                    bus.Busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner-case
// sequences (Start during RUN, reset mid-operation) and random operations
// checked against plain-arithmetic expectations.
module tb_muldiv_unit;
    logic Clock;
    logic ResetN;
    int   checks;
    int   errors;

    muldiv_unit_if #(.WIDTH(16), .ADDR_W(2)) bus ();

    muldiv_unit #(.WIDTH(16), .ADDR_W(2)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [1:0]  dest;
        logic [15:0] expData;
        logic        expDbz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result from ordinary integer arithmetic.
    function automatic logic [15:0] refResult(input logic [15:0] a, input logic [15:0] b,
                                              input logic [1:0] op);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            2'd0: return p[15:0];
            2'd1: return p[31:16];
            2'd2: return (b == 16'd0) ? 16'hFFFF : a / b;
            default: return (b == 16'd0) ? a : a % b;
        endcase
    endfunction

    // Issue one operation and watch the write port for 20 cycles after the Start edge.
    task automatic doOp(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input logic [1:0] dest,
                        input logic [15:0] expData, input logic expDbz, input bit disturb);
        int writes;
        int seenAt;
        int strayDbz;
        logic [15:0] gotData;
        logic [1:0]  gotReg;
        logic        gotDbz;
        writes = 0; seenAt = 0; strayDbz = 0;
        gotData = '0; gotReg = '0; gotDbz = 1'b0;
        @(negedge Clock);
        bus.OperandA = a;
        bus.OperandB = b;
        bus.Op       = op;
        bus.DestIn   = dest;
        bus.Start    = 1'b1;
        @(posedge Clock);
        #1;
        bus.Start = 1'b0;
        check({name, ".busy_E0"}, 32'(bus.Busy), 32'd1);
        if (disturb) begin
            bus.OperandA = ~a;
            bus.OperandB = b ^ 16'h5A5A;
            bus.Op       = ~op;
            bus.DestIn   = ~dest;
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clock);
            #1;
            bus.Start = (disturb && k == 5);
            if (bus.RegWrite) begin
                writes++;
                seenAt  = k;
                gotData = bus.WriteData;
                gotReg  = bus.WriteReg;
                gotDbz  = bus.DivByZero;
            end else if (bus.DivByZero) begin
                strayDbz++;
            end
        end
        bus.Start = 1'b0;
        check({name, ".writes"}, 32'(writes), 32'd1);
        check({name, ".latency"}, 32'(seenAt + 1), 32'd17);
        check({name, ".data"}, 32'(gotData), 32'(expData));
        check({name, ".reg"}, 32'(gotReg), 32'(dest));
        check({name, ".dbz"}, 32'(gotDbz), 32'(expDbz));
        check({name, ".dbz_stray"}, 32'(strayDbz), 32'd0);
        check({name, ".busy_end"}, 32'(bus.Busy), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        int   noWrites;
        checks = 0;
        errors = 0;

        vecs[0] = '{a:16'd3,     b:16'd5,     op:2'd0, dest:2'd2, expData:16'h000F, expDbz:1'b0};
        vecs[1] = '{a:16'hFFFF,  b:16'hFFFF,  op:2'd1, dest:2'd1, expData:16'hFFFE, expDbz:1'b0};
        vecs[2] = '{a:16'hFFFF,  b:16'hFFFF,  op:2'd0, dest:2'd3, expData:16'h0001, expDbz:1'b0};
        vecs[3] = '{a:16'd100,   b:16'd7,     op:2'd2, dest:2'd0, expData:16'h000E, expDbz:1'b0};
        vecs[4] = '{a:16'd100,   b:16'd7,     op:2'd3, dest:2'd1, expData:16'h0002, expDbz:1'b0};
        vecs[5] = '{a:16'h8000,  b:16'h0001,  op:2'd2, dest:2'd2, expData:16'h8000, expDbz:1'b0};
        vecs[6] = '{a:16'h1234,  b:16'h0000,  op:2'd2, dest:2'd3, expData:16'hFFFF, expDbz:1'b1};
        vecs[7] = '{a:16'h1234,  b:16'h0000,  op:2'd3, dest:2'd0, expData:16'h1234, expDbz:1'b1};

        bus.Start = 1'b0; bus.Op = '0; bus.OperandA = '0; bus.OperandB = '0; bus.DestIn = '0;
        ResetN = 1'b0;
        #1;
        check("rst.busy", 32'(bus.Busy), 32'd0);
        check("rst.regwrite", 32'(bus.RegWrite), 32'd0);
        check("rst.data", 32'(bus.WriteData), 32'd0);
        check("rst.reg", 32'(bus.WriteReg), 32'd0);
        check("rst.dbz", 32'(bus.DivByZero), 32'd0);
        #22;
        ResetN = 1'b1;

        for (int i = 0; i < 8; i++) begin
            doOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].dest,
                 vecs[i].expData, vecs[i].expDbz, 1'b0);
        end

        // Start pulse during RUN and operand changes after capture must be ignored.
        doOp("ignore_start", 16'h0123, 16'h0045, 2'd0, 2'd1,
             refResult(16'h0123, 16'h0045, 2'd0), 1'b0, 1'b1);

        // Reset in the middle of a multiply.
        @(negedge Clock);
        bus.OperandA = 16'h00FF; bus.OperandB = 16'h0101; bus.Op = 2'd0; bus.DestIn = 2'd3;
        bus.Start = 1'b1;
        @(posedge Clock);
        #1;
        bus.Start = 1'b0;
        for (int k = 1; k <= 8; k++) @(posedge Clock);
        #2;
        ResetN = 1'b0;
        #1;
        check("abort.busy", 32'(bus.Busy), 32'd0);
        check("abort.regwrite", 32'(bus.RegWrite), 32'd0);
        check("abort.data", 32'(bus.WriteData), 32'd0);
        check("abort.reg", 32'(bus.WriteReg), 32'd0);
        check("abort.dbz", 32'(bus.DivByZero), 32'd0);
        noWrites = 0;
        for (int k = 0; k < 30; k++) begin
            #7;
            if (k == 4) ResetN = 1'b1;
            if (bus.RegWrite) noWrites++;
        end
        check("abort.no_write", 32'(noWrites), 32'd0);
        doOp("after_reset", 16'h00FF, 16'h0101, 2'd0, 2'd3,
             refResult(16'h00FF, 16'h0101, 2'd0), 1'b0, 1'b0);

        // Random operations against integer arithmetic.
        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic [1:0]  rop;
            logic [1:0]  rd;
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            rop = 2'($urandom_range(0, 3));
            rd  = 2'($urandom_range(0, 3));
            doOp($sformatf("rand%0d", i), ra, rb, rop, rd, refResult(ra, rb, rop),
                 rop[1] && (rb == 16'd0), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
